// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Sequencer states: normal issue, or inside a multi-cycle load-use stall.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    // The five pipeline control strobes, grouped so each resolution
    // can be written as one constant.
    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic if_flush;
        logic id_ex_bubble;
        logic ex_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET      = '{pc_load: 1'b0, if_id_load: 1'b0, if_flush: 1'b1, id_ex_bubble: 1'b1, ex_hold: 1'b0};
    localparam ctrl_t CTRL_FREEZE     = '{pc_load: 1'b0, if_id_load: 1'b0, if_flush: 1'b0, id_ex_bubble: 1'b0, ex_hold: 1'b1};
    localparam ctrl_t CTRL_BRANCH     = '{pc_load: 1'b1, if_id_load: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b1, ex_hold: 1'b0};
    localparam ctrl_t CTRL_BUBBLE     = '{pc_load: 1'b0, if_id_load: 1'b0, if_flush: 1'b0, id_ex_bubble: 1'b1, ex_hold: 1'b0};
    localparam ctrl_t CTRL_FETCH_WAIT = '{pc_load: 1'b0, if_id_load: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b0, ex_hold: 1'b0};
    localparam ctrl_t CTRL_RUN        = '{pc_load: 1'b1, if_id_load: 1'b1, if_flush: 1'b0, id_ex_bubble: 1'b0, ex_hold: 1'b0};

    // Instruction word that a flushed IF/ID register stands for (addi x0,x0,0).
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detector.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write. Purely combinational so the forwarding
// unit can share it.
module load_use_detector (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    // x0 is hard-wired to zero, so a load "into" it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Control outputs are
// combinational (Mealy) from the current state and this cycle's inputs;
// state and statistics advance on the rising clock edge.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    import pipeline_hazard_ctrl_pkg::*;

    // Cycles still to stall after the hazard cycle itself.
    localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_STALL - 1);
    localparam bit         LU_MULTI  = (LOAD_USE_STALL > 1);

    state_t           state_reg, state_next;
    logic [1:0]       lu_cnt_reg, lu_cnt_next;
    logic [CNT_W-1:0] stall_cycles_reg, flush_events_reg;
    ctrl_t            ctrl;
    logic             flush_inc;
    logic             hazard;

    load_use_detector u_load_use_detector (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    // Fixed-priority resolution of this cycle's events into control strobes and next state.
    always_comb begin
        ctrl        = CTRL_RUN;
        state_next  = state_reg;
        lu_cnt_next = lu_cnt_reg;
        flush_inc   = 1'b0;
        if (reset) begin
            ctrl        = CTRL_RESET;
            state_next  = ST_RUN;
            lu_cnt_next = 2'd0;
        end else if (dmem_busy) begin
            // Whole pipeline freezes; a pending stall or redirect resumes afterwards.
            ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
            // Redirect wins over any stall: the stalled ID instruction is squashed anyway.
            ctrl        = CTRL_BRANCH;
            state_next  = ST_RUN;
            lu_cnt_next = 2'd0;
            flush_inc   = 1'b1;
        end else if (state_reg == ST_LU_STALL) begin
            ctrl        = CTRL_BUBBLE;
            lu_cnt_next = lu_cnt_reg - 2'd1;
            if (lu_cnt_reg <= 2'd1) begin
                state_next = ST_RUN;
            end
        end else if (hazard) begin
            ctrl = CTRL_BUBBLE;
            if (LU_MULTI) begin
                state_next  = ST_LU_STALL;
                lu_cnt_next = LU_RELOAD;
            end
        end else if (!imem_ready) begin
            // Fetch wait: PC holds while a nop is pushed into ID.
            ctrl = CTRL_FETCH_WAIT;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            lu_cnt_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            lu_cnt_reg <= lu_cnt_next;
        end
    end

    // Saturating statistics: every non-reset cycle without a PC update, and every redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_reg <= '0;
            flush_events_reg <= '0;
        end else begin
            if (!ctrl.pc_load && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
            if (flush_inc && (flush_events_reg != {CNT_W{1'b1}})) begin
                flush_events_reg <= flush_events_reg + CNT_W'(1);
            end
        end
    end

    assign pc_load      = ctrl.pc_load;
    assign if_id_load   = ctrl.if_id_load;
    assign if_flush     = ctrl.if_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign ex_hold      = ctrl.ex_hold;
    assign stall_cycles = stall_cycles_reg;
    assign flush_events = flush_events_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, all checked through a scoreboard queue.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Expected control word order: {pc_load, if_id_load, if_flush, id_ex_bubble, ex_hold}
    localparam logic [4:0] O_RST = 5'b00110;
    localparam logic [4:0] O_FRZ = 5'b00001;
    localparam logic [4:0] O_BR  = 5'b11110;
    localparam logic [4:0] O_LU  = 5'b00010;
    localparam logic [4:0] O_IW  = 5'b01100;
    localparam logic [4:0] O_RUN = 5'b11000;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       imr;
        logic       busy;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  outs;
        logic        chk_cnt;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy;
    logic        pc_load, if_id_load, if_flush, id_ex_bubble, ex_hold;
    logic [15:0] stall_cycles, flush_events;
    logic        s_pc_load, s_if_id_load, s_if_flush, s_id_ex_bubble, s_ex_hold;
    logic [1:0]  s_stall_cycles, s_flush_events;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;
    logic        m_valid = 1'b0;
    vec_t        tbl[$];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .pc_load(pc_load), .if_id_load(if_id_load),
        .if_flush(if_flush), .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // Narrow-counter, single-bubble variant sharing the same stimulus.
    pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .pc_load(s_pc_load), .if_id_load(s_if_id_load),
        .if_flush(s_if_flush), .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold),
        .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
    );

    function automatic vec_t mk(string name, logic rst, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic mr, logic [4:0] rd,
                                logic br, logic imr, logic busy, logic [4:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.mr = mr; v.rd = rd; v.br = br; v.imr = imr; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show for it.
    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clock);
        #1;
        reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_branch_taken = v.br; imem_ready = v.imr; dmem_busy = v.busy;
        e.name = v.name; e.outs = v.exp; e.chk_cnt = m_valid; e.stall = m_stall; e.flush = m_flush;
        sb.push_back(e);
        if (v.rst) begin
            m_stall = 16'd0; m_flush = 16'd0; m_valid = 1'b1;
        end else begin
            if (!v.exp[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (!v.busy && v.br && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Scoreboard: compare the just-driven cycle away from the rising edge.
    always @(negedge clock) begin
        exp_t e;
        logic [4:0] act;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {pc_load, if_id_load, if_flush, id_ex_bubble, ex_hold};
            $display("tx %-14s ctrl=%b stall=%0d flush=%0d", e.name, act, stall_cycles, flush_events);
            checks++;
            if (act !== e.outs) begin
                errors++;
                $display("FAIL %s ctrl got %b want %b", e.name, act, e.outs);
            end
            if (e.chk_cnt) begin
                checks++;
                if (stall_cycles !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall_cycles got %0d want %0d", e.name, stall_cycles, e.stall);
                end
                checks++;
                if (flush_events !== e.flush) begin
                    errors++;
                    $display("FAIL %s flush_events got %0d want %0d", e.name, flush_events, e.flush);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
        $display("nop word %h", NOP_WORD);

        // Single-cycle vectors; none of them leaves the RUN state.
        //              name            rst rs1    rs2    u1 u2 mr rd     br imr busy exp
        tbl.push_back(mk("reset",        1, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 0, O_RST));
        tbl.push_back(mk("plain_run",    0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  0, 1, 0, O_RUN));
        tbl.push_back(mk("ld_no_use",    0, 5'd5,  5'd5,  0, 0, 1, 5'd5,  0, 1, 0, O_RUN));
        tbl.push_back(mk("ld_x0_rs1",    0, 5'd0,  5'd3,  1, 1, 1, 5'd0,  0, 1, 0, O_RUN));
        tbl.push_back(mk("ld_rs2_unused",0, 5'd6,  5'd5,  1, 0, 1, 5'd5,  0, 1, 0, O_RUN));
        tbl.push_back(mk("alu_dep",      0, 5'd5,  5'd1,  1, 1, 0, 5'd5,  0, 1, 0, O_RUN));
        tbl.push_back(mk("fetch_wait",   0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  0, 0, 0, O_IW));
        tbl.push_back(mk("branch",       0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  1, 1, 0, O_BR));
        tbl.push_back(mk("branch_iw",    0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  1, 0, 0, O_BR));
        tbl.push_back(mk("busy",         0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  0, 1, 1, O_FRZ));
        tbl.push_back(mk("busy_branch",  0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  1, 1, 1, O_FRZ));
        tbl.push_back(mk("busy_hazard",  0, 5'd5,  5'd2,  1, 1, 1, 5'd5,  0, 0, 1, O_FRZ));
        tbl.push_back(mk("run_again",    0, 5'd1,  5'd2,  1, 1, 0, 5'd0,  0, 1, 0, O_RUN));
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        // lw x5 in EX, add x6,x5,x1 in ID: two bubbles with the 2-stall build,
        // one with the single-stall build.
        drive(mk("lu_hazard",  0, 5'd5, 5'd1, 1, 1, 1, 5'd5, 0, 1, 0, O_LU));
        @(negedge clock); #2; chk("sat_lu_first_pc", 16'(s_pc_load), 16'd0);
        drive(mk("lu_stall",   0, 5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 1, 0, O_LU));
        @(negedge clock); #2; chk("sat_lu_second_pc", 16'(s_pc_load), 16'd1);
        drive(mk("lu_done",    0, 5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 1, 0, O_RUN));

        // Hazard together with a fetch wait: hazard wins, stall then also beats fetch wait.
        drive(mk("lu_iw",      0, 5'd7, 5'd0, 1, 0, 1, 5'd7, 0, 0, 0, O_LU));
        drive(mk("lu_stall_iw",0, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, O_LU));
        drive(mk("iw_after",   0, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, O_IW));

        // Hazard and branch in the same cycle: redirect only, stays in RUN.
        drive(mk("lu_branch",  0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, O_BR));
        drive(mk("br_then_run",0, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 1, 0, O_RUN));

        // Branch while stalled cancels the remaining bubble.
        drive(mk("lu_hazard2", 0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 1, 0, O_LU));
        drive(mk("stall_br",   0, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 1, 0, O_BR));
        drive(mk("cancelled",  0, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 1, 0, O_RUN));

        // Freeze for 4 cycles in the middle of a load-use stall, then the last bubble.
        drive(mk("lu_hazard3", 0, 5'd4, 5'd4, 0, 1, 1, 5'd4, 0, 1, 0, O_LU));
        for (int i = 0; i < 4; i++)
            drive(mk("stall_busy", 0, 5'd4, 5'd4, 0, 1, 0, 5'd0, 0, 1, 1, O_FRZ));
        drive(mk("stall_resume",0, 5'd4, 5'd4, 0, 1, 0, 5'd0, 0, 1, 0, O_LU));
        drive(mk("resume_done",0, 5'd4, 5'd4, 0, 1, 0, 5'd0, 0, 1, 0, O_RUN));

        // Reset held 3 cycles during a stall; RUN and zero counters afterwards.
        drive(mk("lu_hazard4", 0, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 1, 0, O_LU));
        for (int i = 0; i < 3; i++)
            drive(mk("mid_reset", 1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 1, 0, O_RST));
        drive(mk("post_reset", 0, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 1, 0, O_RUN));

        // Fetch wait long enough to saturate the 2-bit counter.
        drive(mk("reset_sat",  1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_RST));
        for (int i = 0; i < 5; i++)
            drive(mk("iw_sat",    0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0, O_IW));
        drive(mk("iw_sat_end", 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 0, O_RUN));
        @(negedge clock); #2; chk("sat_stall_cycles", 16'(s_stall_cycles), 16'd3);
        for (int i = 0; i < 4; i++)
            drive(mk("br_sat",    0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 1, 0, O_BR));
        drive(mk("br_sat_end", 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1, 0, O_RUN));
        @(negedge clock); #2; chk("sat_flush_events", 16'(s_flush_events), 16'd3);
        chk("sat_stall_hold", 16'(s_stall_cycles), 16'd3);

        @(posedge clock);
        @(negedge clock); #2;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
